// File: rtl/send_mailbox.sv
// Four-entry send mailbox: FIFO of {channel tag, data word} between decode and consumer.
// Optional parity storage enabled by defining SEND_MAILBOX_PARITY_EN.
module send_mailbox (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send,
  input  logic        send_sel,
  input  logic [15:0] send_data,
  output logic        send_stall,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_chan,
  output logic        out_parity,
  output logic [2:0]  level,
  output logic        overflow,
  input  logic        clr_ovf
);

  typedef enum logic [2:0] {
    ST_EMPTY   = 3'b001,
    ST_PARTIAL = 3'b010,
    ST_FULL    = 3'b100
  } occ_state_e;

  occ_state_e  state_q, state_d;
  logic [2:0]  level_q, level_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic        enq;
  logic        deq;

  logic [15:0] mem_data_q [4];
  logic        mem_chan_q [4];

`ifdef SEND_MAILBOX_PARITY_EN
  logic        mem_par_q  [4];

  function automatic logic calc_parity(input logic sel, input logic [15:0] data);
    calc_parity = ^{sel, data};
  endfunction
`endif

  // Handshake decode and next-state computation for pointers, level and flags
  always_comb begin
    deq        = (state_q != ST_EMPTY) & out_ready;
    enq        = send & ((state_q != ST_FULL) | deq);
    level_d    = level_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    state_d    = state_q;

    case ({enq, deq})
      2'b10:   level_d = level_q + 3'd1;
      2'b01:   level_d = level_q - 3'd1;
      default: level_d = level_q;
    endcase

    if (enq) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (deq) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case (level_d)
      3'd0:    state_d = ST_EMPTY;
      3'd4:    state_d = ST_FULL;
      default: state_d = ST_PARTIAL;
    endcase

    // A drop sets the flag even when software clears it in the same cycle
    if (send & (state_q == ST_FULL) & ~deq) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      level_q    <= 3'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array is intentionally left unreset; contents are ignored while empty
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_data_q[wr_ptr_q] <= send_data;
      mem_chan_q[wr_ptr_q] <= send_sel;
`ifdef SEND_MAILBOX_PARITY_EN
      mem_par_q[wr_ptr_q]  <= calc_parity(send_sel, send_data);
`endif
    end
  end

  assign out_valid  = (state_q != ST_EMPTY);
  assign send_stall = (state_q == ST_FULL);
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign out_data   = mem_data_q[rd_ptr_q];
  assign out_chan   = mem_chan_q[rd_ptr_q];
`ifdef SEND_MAILBOX_PARITY_EN
  assign out_parity = mem_par_q[rd_ptr_q];
`else
  assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_send_mailbox.sv
// Self-checking bench for send_mailbox: queue-based reference model plus directed vectors.
module tb_send_mailbox;

  logic        clk = 1'b0;
  logic        rst_n, send, send_sel, out_ready, clr_ovf;
  logic [15:0] send_data;
  logic        send_stall, out_valid, out_chan, out_parity, overflow;
  logic [15:0] out_data;
  logic [2:0]  level;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  logic [16:0] mq[$];   // {chan, data}
  logic        m_ovf = 1'b0;

  send_mailbox dut (
    .clk(clk), .rst_n(rst_n), .send(send), .send_sel(send_sel), .send_data(send_data),
    .send_stall(send_stall), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chan(out_chan), .out_parity(out_parity),
    .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_parity(input logic [16:0] e);
`ifdef SEND_MAILBOX_PARITY_EN
    return ^e;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: mailbox as a bounded queue updated from the sampled inputs
  always @(posedge clk) begin
    bit full, d, e;
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      full = (mq.size() == 4);
      d    = (mq.size() > 0) && out_ready;
      e    = send && (!full || d);
      if (send && full && !d) m_ovf = 1'b1;
      else if (clr_ovf)        m_ovf = 1'b0;
      if (d) void'(mq.pop_front());
      if (e) mq.push_back({send_sel, send_data});
    end
  end

  // Every-cycle compare of DUT outputs against the model
  always @(negedge clk) begin
    if (started) begin
      chk("valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
      chk("level", {29'd0, level}, mq.size());
      chk("stall", {31'd0, send_stall}, {31'd0, mq.size() == 4});
      chk("ovf", {31'd0, overflow}, {31'd0, m_ovf});
      if (mq.size() != 0) begin
        chk("data", {16'd0, out_data}, {16'd0, mq[0][15:0]});
        chk("chan", {31'd0, out_chan}, {31'd0, mq[0][16]});
        chk("parity", {31'd0, out_parity}, {31'd0, exp_parity(mq[0])});
      end
    end
  end

  task automatic cyc(input logic s, input logic sel, input logic [15:0] d,
                     input logic rdy, input logic clr, input logic rn);
    send = s; send_sel = sel; send_data = d; out_ready = rdy; clr_ovf = clr; rst_n = rn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b0);
    started = 1'b1;
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_stall", {31'd0, send_stall}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);

    // Single word, 1-cycle latency
    cyc(1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0, 1'b1);
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_data", {16'd0, out_data}, 32'h0000BEEF);
    chk("single_chan", {31'd0, out_chan}, 32'd0);
    chk("single_level", {29'd0, level}, 32'd1);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    chk("single_drain", {29'd0, level}, 32'd0);

    // Fill, overflow, drain order
    for (int i = 1; i <= 4; i++) cyc(1'b1, i[0], 16'(i), 1'b0, 1'b0, 1'b1);
    chk("fill_level", {29'd0, level}, 32'd4);
    chk("fill_stall", {31'd0, send_stall}, 32'd1);
    cyc(1'b1, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b1);
    chk("fill_ovf", {31'd0, overflow}, 32'd1);
    chk("fill_ovf_level", {29'd0, level}, 32'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", {16'd0, out_data}, i);
      cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    end
    chk("drain_empty", {31'd0, out_valid}, 32'd0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    chk("clr_ovf", {31'd0, overflow}, 32'd0);

    // Full with simultaneous send and deq
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 16'h0010 + 16'(i), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 16'h00AA, 1'b1, 1'b0, 1'b1);
    chk("simul_level", {29'd0, level}, 32'd4);
    chk("simul_head", {16'd0, out_data}, 32'h00000012);
    chk("simul_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    chk("simul_fourth", {16'd0, out_data}, 32'h000000AA);
    chk("simul_fourth_chan", {31'd0, out_chan}, 32'd1);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Streaming wrap-around
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, i[1], 16'h0100 + 16'(i), 1'b1, 1'b0, 1'b1);
      chk("stream_data", {16'd0, out_data}, 32'h100 + i);
      chk("stream_level", {31'd0, level <= 3'd1}, 32'd1);
      chk("stream_ovf", {31'd0, overflow}, 32'd0);
    end
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Reset mid-operation with overflow set
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 16'h0020 + 16'(i), 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    chk("pre_rst_level", {29'd0, level}, 32'd3);
    chk("pre_rst_ovf", {31'd0, overflow}, 32'd1);
    cyc(1'b1, 1'b0, 16'h0030, 1'b1, 1'b0, 1'b0);
    chk("mid_rst_level", {29'd0, level}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);

    // Set wins over clear
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'h0040 + 16'(i), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 16'h0050, 1'b0, 1'b1, 1'b1);
    chk("set_over_clr", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);

    // Parity
    cyc(1'b1, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b1);
`ifdef SEND_MAILBOX_PARITY_EN
    chk("parity_7", {31'd0, out_parity}, 32'd1);
`else
    chk("parity_off_7", {31'd0, out_parity}, 32'd0);
`endif
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b1);
`ifdef SEND_MAILBOX_PARITY_EN
    chk("parity_3c", {31'd0, out_parity}, 32'd1);
`else
    chk("parity_off_3c", {31'd0, out_parity}, 32'd0);
`endif
    cyc(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
